// File: rtl/paridad_serial_tx.sv
// paridad_serial_tx
// Serialises the two 3-bit operands and their upstream parity bit as one
// UART-style frame, LSB first. The frame is start, A[2:0], B[2:0], parity, stop.
// The block also flags a mismatch between the upstream parity bit and a local
// XOR of the operands. It drives the board's serial/debug pin, which idles high.
module paridad_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 5208  // clock cycles per serial bit, >= 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic       BP,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       parity_err
);

    localparam int unsigned     BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      DATA_LAST = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q,  baud_d;
    logic [2:0]          bit_q,   bit_d;
    logic [5:0]          shift_q, shift_d;
    logic                bp_q,    bp_d;
    logic                perr_q,  perr_d;
    logic                tx_q,    tx_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic                bit_end;

    // Registers every piece of state. Reset puts the line in its idle-high state
    // and abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            bp_q    <= 1'b0;
            perr_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here. Every flop updates from the
            // pre-edge values, so the order of these lines does not matter.
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            bp_q    <= bp_d;
            perr_q  <= perr_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bit_end = (baud_q == BAUD_LAST);

    // Computes the next state and the counters, and accepts a new frame from IDLE.
    always_comb begin
        // NOTE: every variable written below receives a default first. That keeps
        // any path through the case from holding a value and inferring a latch.
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        bp_d    = bp_q;
        perr_d  = perr_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (start) begin
                    shift_d = {B, A};
                    bp_d    = BP;
                    perr_d  = BP ^ (^{A, B});
                    state_d = S_START;
                end
            end
            S_START: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Decodes the registered line level and busy flag from the next state.
    // Both outputs then change on the same edge as the state and stay glitch-free.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        unique case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = bp_d;      // sent as received so the far end can see a bad bit
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_paridad_serial_tx.sv
// Testbench for paridad_serial_tx with CLKS_PER_BIT = 4, so a frame is 36 cycles.
// Expected line levels come from a frame model built from the operands.
module tb_paridad_serial_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 9 * CPB;

    logic       clk;
    logic       rst_n;
    logic [2:0] A;
    logic [2:0] B;
    logic       BP;
    logic       start;
    logic       tx;
    logic       busy;
    logic       done;
    logic       parity_err;

    int checks;
    int errors;
    int cyc;
    int last_done_cyc;

    paridad_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .BP         (BP),
        .start      (start),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .parity_err (parity_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the frame's nine bit levels, in the order they go out.
    function automatic logic [8:0] frame_bits(input logic [2:0] a, input logic [2:0] b,
                                              input logic bp);
        logic [8:0] f;
        int         data;
        data = b * 8 + a;
        f[0] = 1'b0;
        for (int i = 0; i < 6; i++) f[i+1] = ((data >> i) % 2) == 1;
        f[7] = bp;
        f[8] = 1'b1;
        return f;
    endfunction

    function automatic logic exp_perr(input logic [2:0] a, input logic [2:0] b,
                                      input logic bp);
        int ones;
        ones = $countones(a) + $countones(b);
        return bp ^ logic'(ones % 2);
    endfunction

    // Sends one frame, checking every cycle through the done pulse.
    // On entry the bench is at a negedge. When hold is clear, start drops after
    // the accept edge. When poke_at >= 0, a second start request with other
    // operands arrives at that frame cycle.
    task automatic run_frame(input logic [2:0] a, input logic [2:0] b, input logic bp,
                             input bit hold, input int poke_at,
                             input logic [2:0] pa, input logic [2:0] pb,
                             output logic perr_out);
        logic [8:0] f;
        logic       pe;
        logic [3:0] obs, exp;
        f  = frame_bits(a, b, bp);
        pe = exp_perr(a, b, bp);
        A = a; B = b; BP = bp; start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (!hold && c == 0) start = 1'b0;
            if (c == poke_at) begin
                start = 1'b1; A = pa; B = pb; BP = ~bp;
            end
            if (!hold && c == poke_at + 1) start = 1'b0;
            obs = {tx, busy, done, parity_err};
            exp = {f[c / CPB], 1'b1, 1'b0, pe};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL frame_cycle c=%0d {tx,busy,done,perr} got=%b exp=%b", c, obs, exp);
            end
        end
        @(negedge clk);
        obs = {tx, busy, done, parity_err};
        exp = {1'b1, 1'b0, 1'b1, pe};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL done_cycle {tx,busy,done,perr} got=%b exp=%b", obs, exp);
        end
        last_done_cyc = cyc;
        perr_out = pe;
    endtask

    // Checks n idle cycles with start low.
    task automatic check_idle(input int n, input logic pe, input string tag);
        logic [3:0] obs, exp;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs = {tx, busy, done, parity_err};
            exp = {1'b1, 1'b0, 1'b0, pe};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s idle i=%0d {tx,busy,done,perr} got=%b exp=%b", tag, i, obs, exp);
            end
        end
    endtask

    task automatic test_reset();
        check_idle(100, 1'b0, "reset_idle");
    endtask

    task automatic test_basic();
        logic pe;
        run_frame(3'b101, 3'b011, 1'b0, 1'b0, -1, 3'b000, 3'b000, pe);
        check_idle(5, pe, "basic_after");
    endtask

    task automatic test_parity_err();
        logic pe;
        run_frame(3'b001, 3'b000, 1'b0, 1'b0, -1, 3'b000, 3'b000, pe);
        check_idle(3, 1'b1, "perr_hold");
        run_frame(3'b001, 3'b000, 1'b1, 1'b0, -1, 3'b000, 3'b000, pe);
        check_idle(3, 1'b0, "perr_clear");
    endtask

    task automatic test_ignore_busy();
        logic pe;
        run_frame(3'b010, 3'b110, 1'b1, 1'b0, 10, 3'b101, 3'b001, pe);
        check_idle(45, pe, "ignore_no_second");
    endtask

    task automatic test_back_to_back();
        logic pe;
        int   t1;
        run_frame(3'b111, 3'b111, 1'b0, 1'b1, -1, 3'b000, 3'b000, pe);
        t1 = last_done_cyc;
        run_frame(3'b111, 3'b111, 1'b0, 1'b1, -1, 3'b000, 3'b000, pe);
        checks++;
        if (last_done_cyc - t1 !== 37) begin
            errors++;
            $display("FAIL b2b_done_spacing got=%0d exp=37", last_done_cyc - t1);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_stop {tx,busy,done} got=%b exp=100", {tx, busy, done});
        end
        check_idle(40, pe, "b2b_after");
    endtask

    task automatic test_reset_mid();
        logic pe;
        A = 3'b110; B = 3'b101; BP = 1'b0; start = 1'b1;
        @(posedge clk);
        // Frame cycles 16..19 carry data bit 3 (B[0]).
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, busy, done, parity_err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_async {tx,busy,done,perr} got=%b exp=1000",
                     {tx, busy, done, parity_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_idle(45, 1'b0, "reset_mid_after");
        run_frame(3'b011, 3'b100, 1'b1, 1'b0, -1, 3'b000, 3'b000, pe);
        check_idle(2, pe, "reset_mid_frame2");
    endtask

    task automatic test_random();
        logic       pe;
        logic [2:0] a, b;
        logic       bp;
        for (int n = 0; n < 10; n++) begin
            a  = 3'($urandom_range(0, 7));
            b  = 3'($urandom_range(0, 7));
            bp = 1'($urandom_range(0, 1));
            run_frame(a, b, bp, 1'b0, -1, 3'b000, 3'b000, pe);
            check_idle(1 + int'($urandom_range(0, 3)), pe, "random_gap");
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; last_done_cyc = 0;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; BP = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_parity_err();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
